// File: rtl/memaccess_pkg.sv
// memaccess_pkg: shared widths, size codes and state encodings for the load/store initiator
package memaccess_pkg;
    localparam int WIDTH = 64;
    localparam int unsigned MEMSIZE_DEF = 256;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LD = 3'd1;
    localparam logic [2:0] S_RD = 3'd2;
    localparam logic [2:0] S_WR = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
endpackage

// File: rtl/memaccess_if.sv
// memaccess_if: datapath request/response and data memory port of the load/store initiator
//   slave  - the initiator: takes req_* and mem_out, drives req_ready, resp_* and mem_*
//   master - the datapath plus memory responder
interface memaccess_if;
    import memaccess_pkg::*;
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_fault;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_in;
    logic             mem_rden;
    logic             mem_wren;
    logic [WIDTH-1:0] mem_out;
    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_in, mem_rden, mem_wren
    );
    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_in, mem_rden, mem_wren
    );
endinterface

// File: rtl/memaccess_align.sv
// memaccess_align: big-endian sub-word extraction for loads and merge for read-modify-write stores
//   size_i/signed_i - access size code and sign-extension request
//   mem_out_i       - word read from memory, requested bytes at the top
//   wdata_i         - store data, significant bits at the bottom
//   load_o          - extended load value; merged_o - word to write back
module memaccess_align
    import memaccess_pkg::*;
(
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] mem_out_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] load_o,
    output logic [WIDTH-1:0] merged_o
);
    logic sx;
    assign sx = signed_i & mem_out_i[63];
    always_comb begin
        load_o = size_i == SZ_BYTE ? {{56{sx}}, mem_out_i[63:56]} :
                 size_i == SZ_HALF ? {{48{sx}}, mem_out_i[63:48]} :
                 size_i == SZ_WORD ? {{32{sx}}, mem_out_i[63:32]} : mem_out_i;
        merged_o = size_i == SZ_BYTE ? {wdata_i[7:0], mem_out_i[55:0]} :
                   size_i == SZ_HALF ? {wdata_i[15:0], mem_out_i[47:0]} :
                   size_i == SZ_WORD ? {wdata_i[31:0], mem_out_i[31:0]} : wdata_i;
    end
endmodule

// File: rtl/memaccess.sv
// memaccess: LDUR/STUR initiator between the EX/MEM datapath and big-endian data memory
//   clk/reset - clock and synchronous active-high reset
//   bus       - request/response handshake and memory port (memaccess_if.slave)
module memaccess
    import memaccess_pkg::*;
#(
    parameter int unsigned MEMSIZE = MEMSIZE_DEF
) (
    input logic        clk,
    input logic        reset,
    memaccess_if.slave bus
);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MEMSIZE - 8);
    logic [2:0]       state_q, state_d;
    logic [1:0]       size_q;
    logic             signed_q;
    logic             fault_q;
    logic [WIDTH-1:0] addr_q, wdata_q, merged_q, rdata_q;
    logic [WIDTH-1:0] load, merged;
    logic             accept, fault, busy_mem;
    assign accept = state_q == S_IDLE && bus.req_valid;
    assign fault = bus.req_addr > LIMIT;
    always_comb begin
        state_d = state_q == S_IDLE ? (!bus.req_valid ? S_IDLE :
                                       fault ? S_RESP :
                                       !bus.req_store ? S_LD :
                                       bus.req_size == SZ_DOUBLE ? S_WR : S_RD) :
                  state_q == S_LD ? S_RESP :
                  state_q == S_RD ? S_WR :
                  state_q == S_WR ? S_RESP : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            size_q   <= '0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                fault_q  <= fault;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                merged_q <= bus.req_wdata;
                rdata_q  <= '0;
            end
            if (state_q == S_LD) rdata_q <= load;
            if (state_q == S_RD) merged_q <= merged;
        end
    end
    memaccess_align u_align (
        .size_i   (size_q),
        .signed_i (signed_q),
        .mem_out_i(bus.mem_out),
        .wdata_i  (wdata_q),
        .load_o   (load),
        .merged_o (merged)
    );
    assign busy_mem = state_q == S_LD || state_q == S_RD || state_q == S_WR;
    assign bus.req_ready = state_q == S_IDLE;
    assign bus.resp_valid = state_q == S_RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.mem_rden = state_q == S_LD || state_q == S_RD;
    // a write must never land on a reset edge
    assign bus.mem_wren = state_q == S_WR && !reset;
    assign bus.mem_addr = busy_mem ? addr_q : '0;
    assign bus.mem_in = state_q == S_WR ? merged_q : '0;
endmodule
